// File: rtl/tx_sched_pkg.sv
// Shared encodings and default sizes for the 32-bit word scheduler in front of
// the byte-wide UART transmitter.
package tx_sched_pkg;

  localparam int N_DATA_DEF  = 8;
  localparam int N_BYTES_DEF = 4;
  localparam int NB_WORD_DEF = N_DATA_DEF * N_BYTES_DEF;
  localparam int NB_STATE    = 5;

  // Width of a counter or index addressing n items; never narrower than 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NB_IDX_DEF = idx_width(N_BYTES_DEF);

  typedef enum logic [NB_STATE-1:0] {
    S_IDLE       = 5'b00001,
    S_SEND       = 5'b00010,
    S_WAIT_BUSY  = 5'b00100,
    S_WAIT_READY = 5'b01000,
    S_NEXT       = 5'b10000
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from pointer+1 cyclically for the first active
// request; the pointer moves to the winner only when the owner accepts.
module rr_arbiter
  import tx_sched_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int NB_RIDX = idx_width(N_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic               update,
  output logic [N_REQ-1:0]   winner,
  output logic [NB_RIDX-1:0] winner_idx
);

  logic [NB_RIDX-1:0] pointer_reg;

  always_comb begin
    int cand;
    logic [NB_RIDX-1:0] cidx;
    logic found;
    cand       = 0;
    cidx       = '0;
    found      = 1'b0;
    winner     = '0;
    winner_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(pointer_reg) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cidx = NB_RIDX'(cand);
      if (!found && req[cidx]) begin
        found        = 1'b1;
        winner[cidx] = 1'b1;
        winner_idx   = cidx;
      end
    end
  end

  // Reset to the last requester so requester 0 has first priority.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pointer_reg <= NB_RIDX'(N_REQ - 1);
    end else if (update) begin
      pointer_reg <= winner_idx;
    end
  end

endmodule

// File: rtl/tx_word_scheduler.sv
// Arbitrates whole-word transmit requests and feeds the chosen word to the UART
// transmitter one byte at a time, least significant byte first.
module tx_word_scheduler
  import tx_sched_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int N_DATA   = N_DATA_DEF,
  parameter int N_BYTES  = N_BYTES_DEF,
  parameter int NB_WORD  = N_DATA * N_BYTES,
  parameter int NB_STATE = tx_sched_pkg::NB_STATE
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*NB_WORD-1:0] word_in,
  output logic [N_REQ-1:0]         grant,
  output logic [N_REQ-1:0]         done,
  output logic                     busy,
  output logic [N_DATA-1:0]        uart_din,
  output logic                     uart_tx_start,
  input  logic                     uart_tx_ready,
  output logic [NB_STATE-1:0]      state
);

  localparam int NB_IDX  = idx_width(N_BYTES);
  localparam int NB_RIDX = idx_width(N_REQ);
  localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(N_BYTES - 1);

  state_t             state_reg;
  logic [NB_IDX-1:0]  idx_reg;
  logic [NB_IDX-1:0]  idx_next;
  logic [NB_WORD-1:0] word_reg;
  logic [N_REQ-1:0]   winner_reg;
  logic [N_REQ-1:0]   grant_reg;
  logic [N_DATA-1:0]  din_reg;
  logic               start_reg;

  logic [NB_WORD-1:0] words [N_REQ];
  logic [NB_WORD-1:0] sel_word;
  logic [N_REQ-1:0]   arb_winner;
  logic [NB_RIDX-1:0] arb_idx;
  logic               accept;
  logic               last_byte;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_words
      assign words[gi] = word_in[gi*NB_WORD +: NB_WORD];
    end
  endgenerate

  assign accept    = (state_reg == S_IDLE) && (|req) && uart_tx_ready;
  assign sel_word  = words[arb_idx];
  assign idx_next  = idx_reg + NB_IDX'(1);
  assign last_byte = (idx_reg == LAST_IDX);

  rr_arbiter #(
    .N_REQ   (N_REQ),
    .NB_RIDX (NB_RIDX)
  ) u_arb (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .update     (accept),
    .winner     (arb_winner),
    .winner_idx (arb_idx)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg  <= S_IDLE;
      idx_reg    <= '0;
      word_reg   <= '0;
      winner_reg <= '0;
      grant_reg  <= '0;
      din_reg    <= '0;
      start_reg  <= 1'b0;
    end else begin
      grant_reg <= '0;
      start_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            word_reg   <= sel_word;
            winner_reg <= arb_winner;
            idx_reg    <= '0;
            grant_reg  <= arb_winner;
            din_reg    <= sel_word[N_DATA-1:0];
            start_reg  <= 1'b1;
            state_reg  <= S_SEND;
          end
        end
        S_SEND: begin
          state_reg <= S_WAIT_BUSY;
        end
        // The transmitter may take a few cycles to leave idle after the strobe.
        S_WAIT_BUSY: begin
          if (!uart_tx_ready) state_reg <= S_WAIT_READY;
        end
        S_WAIT_READY: begin
          if (uart_tx_ready) state_reg <= last_byte ? S_IDLE : S_NEXT;
        end
        S_NEXT: begin
          idx_reg   <= idx_next;
          din_reg   <= word_reg[idx_next*N_DATA +: N_DATA];
          start_reg <= 1'b1;
          state_reg <= S_SEND;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // done is decoded in the final WAIT_READY cycle so busy falls the cycle after.
  assign done = winner_reg &
                {N_REQ{(state_reg == S_WAIT_READY) && uart_tx_ready && last_byte}};

  assign grant         = grant_reg;
  assign busy          = (state_reg != S_IDLE);
  assign uart_din      = din_reg;
  assign uart_tx_start = start_reg;
  assign state         = NB_STATE'(state_reg);

endmodule

// File: tb/tb_tx_word_scheduler.sv
// Directed bench for tx_word_scheduler with a behavioural UART transmitter model.
module tb_tx_word_scheduler;
  import tx_sched_pkg::*;

  localparam int FRAME  = 10;
  localparam int BUDGET = 400;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [63:0] word_in = 64'h0;
  logic [1:0]  grant;
  logic [1:0]  done;
  logic        busy;
  logic [7:0]  uart_din;
  logic        uart_tx_start;
  logic        uart_tx_ready;
  logic [4:0]  state;

  always #5 clock = ~clock;

  tx_word_scheduler dut (
    .clock         (clock),
    .reset         (reset),
    .req           (req),
    .word_in       (word_in),
    .grant         (grant),
    .done          (done),
    .busy          (busy),
    .uart_din      (uart_din),
    .uart_tx_start (uart_tx_start),
    .uart_tx_ready (uart_tx_ready),
    .state         (state)
  );

  // UART transmitter model: ready drops drop_delay cycles after the strobe, stays low FRAME cycles.
  logic m_active;
  int   m_cnt;
  int   m_pend;
  int   drop_delay = 0;
  int   dup_start = 0;
  logic force_low = 1'b0;

  assign uart_tx_ready = ~m_active & ~force_low;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0;
      m_cnt    <= 0;
      m_pend   <= 0;
    end else begin
      if (uart_tx_start) begin
        if (m_active || m_pend != 0) dup_start <= dup_start + 1;
        else if (drop_delay == 0) begin
          m_active <= 1'b1;
          m_cnt    <= FRAME;
        end else m_pend <= drop_delay;
      end
      if (m_pend != 0) begin
        m_pend <= m_pend - 1;
        if (m_pend == 1) begin
          m_active <= 1'b1;
          m_cnt    <= FRAME;
        end
      end
      if (m_active) begin
        if (m_cnt == 1) m_active <= 1'b0;
        m_cnt <= m_cnt - 1;
      end
    end
  end

  int         grant_q[$];
  int         done_q[$];
  logic [7:0] byte_q[$];
  int         tx_cnt = 0;
  int         inv_err = 0;
  int         n_vec = 0;
  int         n_fail = 0;

  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        if (grant != 2'b00) grant_q.push_back(grant[1] ? 1 : 0);
        if (done != 2'b00) done_q.push_back(done[1] ? 1 : 0);
        if (uart_tx_start) begin
          byte_q.push_back(uart_din);
          tx_cnt++;
        end
        if (!$onehot0(grant) || !$onehot0(done) || ((|grant) && (|done))) inv_err++;
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: timed out after %0d cycles", name, BUDGET);
  endtask

  task automatic clear_logs();
    grant_q.delete();
    done_q.delete();
    byte_q.delete();
    tx_cnt = 0;
  endtask

  function automatic logic [31:0] first_word();
    if (byte_q.size() < 4) return 32'h0;
    return {byte_q[3], byte_q[2], byte_q[1], byte_q[0]};
  endfunction

  task automatic wait_done(input int n);
    int t = 0;
    while (done_q.size() < n && t < BUDGET) begin
      tick();
      t++;
    end
    if (done_q.size() < n) timeout_fail("done_wait");
  endtask

  // One complete word: request, drop req after grant (optionally alter word 0), wait for done.
  task automatic xfer(input logic [1:0] r, input logic chg, input logic [31:0] neww,
                      output int g, output int d, output logic [31:0] w, output int nb);
    int t = 0;
    clear_logs();
    req = r;
    while (grant_q.size() == 0 && t < BUDGET) begin
      tick();
      t++;
    end
    if (grant_q.size() == 0) begin
      timeout_fail("grant_wait");
      req = 2'b00;
      g = -1; d = -1; w = 32'h0; nb = 0;
      return;
    end
    req = 2'b00;
    if (chg) word_in[31:0] = neww;
    wait_done(1);
    tick();
    g  = grant_q[0];
    d  = (done_q.size() > 0) ? done_q[0] : -1;
    w  = first_word();
    nb = tx_cnt;
  endtask

  typedef struct {
    logic [1:0]  r;
    logic [31:0] w0;
    logic [31:0] w1;
    int          exp_g;
    logic [31:0] exp_w;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, d, nb, bad, t;
    logic [31:0] w;

    // Pointer starts at 0 here because the single-word sequence before is served to requester 0.
    vecs[0] = '{2'b10, 32'h00000000, 32'h01020304, 1, 32'h01020304};
    vecs[1] = '{2'b11, 32'hA5A5A5A5, 32'h5A5A5A5A, 0, 32'hA5A5A5A5};
    vecs[2] = '{2'b11, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 32'h5A5A5A5A};
    vecs[3] = '{2'b01, 32'h000000FF, 32'hFFFFFFFF, 0, 32'h000000FF};
    vecs[4] = '{2'b11, 32'h80000001, 32'h7FFFFFFE, 1, 32'h7FFFFFFE};
    vecs[5] = '{2'b11, 32'h13579BDF, 32'h2468ACE0, 0, 32'h13579BDF};

    // Reset values
    repeat (3) tick();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_tx_start", 32'(uart_tx_start), 32'h0);
    check("rst_din", 32'(uart_din), 32'h0);
    check("rst_state", 32'(state), 32'h1);
    reset = 1'b1;
    tick();
    tick();

    // Single word 0xDEADBEEF with cycle-exact grant and done/busy timing
    clear_logs();
    word_in[31:0] = 32'hDEADBEEF;
    req = 2'b01;
    tick();
    check("b_grant", 32'(grant), 32'h1);
    check("b_state_send", 32'(state), 32'h2);
    check("b_tx_start", 32'(uart_tx_start), 32'h1);
    check("b_din0", 32'(uart_din), 32'hEF);
    req = 2'b00;
    t = 0;
    while (done == 2'b00 && t < BUDGET) begin
      tick();
      t++;
    end
    if (done == 2'b00) timeout_fail("b_done_wait");
    else begin
      check("b_done", 32'(done), 32'h1);
      check("b_busy_at_done", 32'(busy), 32'h1);
      tick();
      check("b_busy_after", 32'(busy), 32'h0);
      check("b_done_pulse", 32'(done), 32'h0);
    end
    check("b_bytes", first_word(), 32'hDEADBEEF);
    check("b_tx_count", 32'(tx_cnt), 32'd4);
    check("b_grant_count", 32'(grant_q.size()), 32'd1);
    check("b_done_count", 32'(done_q.size()), 32'd1);
    tick();

    // Table of arbitration / data vectors
    foreach (vecs[i]) begin
      word_in = {vecs[i].w1, vecs[i].w0};
      xfer(vecs[i].r, 1'b0, 32'h0, g, d, w, nb);
      check($sformatf("v%0d_grant", i), 32'(g), 32'(vecs[i].exp_g));
      check($sformatf("v%0d_done", i), 32'(d), 32'(vecs[i].exp_g));
      check($sformatf("v%0d_word", i), w, vecs[i].exp_w);
      check($sformatf("v%0d_count", i), 32'(nb), 32'd4);
    end

    // Transmitter not ready: no grant until ready returns, then grant one cycle later
    clear_logs();
    word_in[63:32] = 32'h0BEEF123;
    force_low = 1'b1;
    req = 2'b10;
    bad = 0;
    repeat (6) begin
      tick();
      if (grant != 2'b00 || uart_tx_start) bad++;
    end
    check("nr_no_grant", 32'(bad), 32'h0);
    force_low = 1'b0;
    tick();
    check("nr_grant", 32'(grant), 32'h2);
    req = 2'b00;
    wait_done(1);
    tick();
    check("nr_word", first_word(), 32'h0BEEF123);

    // Word stability after grant
    word_in[31:0] = 32'hCAFEF00D;
    xfer(2'b01, 1'b1, 32'h12345678, g, d, w, nb);
    check("ws_grant", 32'(g), 32'h0);
    check("ws_word", w, 32'hCAFEF00D);

    // Reset during byte 2 aborts the word
    clear_logs();
    word_in[31:0] = 32'h11223344;
    req = 2'b01;
    t = 0;
    while (tx_cnt < 3 && t < BUDGET) begin
      tick();
      t++;
    end
    if (tx_cnt < 3) timeout_fail("rm_byte2_wait");
    req = 2'b00;
    tick();
    tick();
    #1;
    reset = 1'b0;
    #1;
    check("rm_grant", 32'(grant), 32'h0);
    check("rm_done", 32'(done), 32'h0);
    check("rm_busy", 32'(busy), 32'h0);
    check("rm_tx_start", 32'(uart_tx_start), 32'h0);
    check("rm_din", 32'(uart_din), 32'h0);
    check("rm_state", 32'(state), 32'h1);
    check("rm_no_done", 32'(done_q.size()), 32'h0);
    tick();
    reset = 1'b1;
    tick();
    word_in[31:0] = 32'h55667788;
    xfer(2'b01, 1'b0, 32'h0, g, d, w, nb);
    check("rm_restart_grant", 32'(g), 32'h0);
    check("rm_restart_word", w, 32'h55667788);
    check("rm_restart_count", 32'(nb), 32'd4);

    // Slow ready handshake
    drop_delay = 3;
    word_in[63:32] = 32'h0BADC0DE;
    xfer(2'b10, 1'b0, 32'h0, g, d, w, nb);
    check("sr_grant", 32'(g), 32'h1);
    check("sr_done", 32'(d), 32'h1);
    check("sr_word", w, 32'h0BADC0DE);
    check("sr_count", 32'(nb), 32'd4);
    check("sr_dup_start", 32'(dup_start), 32'h0);
    drop_delay = 0;

    // Both requesters held high from reset for four words: order 0,1,0,1
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    clear_logs();
    word_in = {32'hB1B2B3B4, 32'hA1A2A3A4};
    req = 2'b11;
    wait_done(4);
    req = 2'b00;
    tick();
    tick();
    if (grant_q.size() >= 4 && done_q.size() >= 4) begin
      check("rr_grant_order", {16'h0, 4'(grant_q[0]), 4'(grant_q[1]), 4'(grant_q[2]), 4'(grant_q[3])}, 32'h0101);
      check("rr_done_order", {16'h0, 4'(done_q[0]), 4'(done_q[1]), 4'(done_q[2]), 4'(done_q[3])}, 32'h0101);
    end else begin
      timeout_fail("rr_four_words");
    end
    check("rr_first_word", first_word(), 32'hA1A2A3A4);
    check("rr_tx_count", 32'(tx_cnt), 32'd16);

    check("invariants", 32'(inv_err), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_word_scheduler.md
Name: tx_word_scheduler

Overview:
- Sequences the byte-wide UART transmitter so that whole 32-bit words can be sent from several requesters, e.g. the debug unit dumping registers/PC/memory and the step-mode status reporter.
- Arbitrates between requesters round-robin and latches the winner's word.
- Serializes the word LSB-byte-first using the transmitter's tx_start / tx_done_tick handshake.
- Sits between the debug/control logic and the UART TX.

Parameters:
- N_REQ, 2, number of requesters.
- N_DATA, 8, UART byte width.
- N_BYTES, 4, bytes per word.
- NB_WORD, 32, word width; must equal N_DATA*N_BYTES.
- NB_STATE, 5, one-hot FSM state width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester request level.
- word_in  in  N_REQ*NB_WORD  flattened words; requester i occupies [i*NB_WORD +: NB_WORD].
- grant  out  N_REQ  one-hot, 1-cycle pulse: word of requester i accepted.
- done  out  N_REQ  one-hot, 1-cycle pulse: last byte of requester i's word fully transmitted.
- busy  out  1  high in every state except IDLE.
- uart_din  out  N_DATA  byte to transmitter; registered, stable from SEND until the next SEND.
- uart_tx_start  out  1  transmitter start strobe.
- uart_tx_ready  in  1  transmitter tx_done_tick; high as a level while the transmitter is idle.
- state  out  NB_STATE  current FSM state, for debug.

Behaviour:
- Reset (reset=0, asynchronous): all outputs take their reset values immediately.
  - grant=0, done=0, busy=0, uart_tx_start=0, uart_din=0, state=IDLE.
  - byte index=0, latched word=0, round-robin pointer=N_REQ-1 (requester 0 has first priority).
  - Reset mid-word aborts the transfer. The partial word is not retried and no done is issued.
- States (one-hot): IDLE=00001, SEND=00010, WAIT_BUSY=00100, WAIT_READY=01000, NEXT=10000.
- IDLE:
  - Accept only when |req and uart_tx_ready=1.
  - Winner = first asserted req scanning from pointer+1 cyclically.
  - At that edge: latch the winner's word, set pointer=winner, byte index=0, go to SEND.
  - With no req, or with uart_tx_ready=0, stay in IDLE with no grant.
- SEND (exactly 1 cycle):
  - uart_tx_start=1, uart_din=word[idx*N_DATA +: N_DATA].
  - grant[winner]=1, but only in the first SEND of a word.
  - Go to WAIT_BUSY.
- WAIT_BUSY:
  - uart_tx_start=0.
  - Stay until uart_tx_ready=0, i.e. the transmitter has left idle (normally 1 cycle), then go to WAIT_READY.
- WAIT_READY:
  - Stay until uart_tx_ready=1 (stop bit finished).
  - If idx==N_BYTES-1: done[winner]=1 for 1 cycle and go to IDLE.
  - Otherwise go to NEXT.
- NEXT (1 cycle): idx=idx+1, go to SEND.
- Timing:
  - Acceptance-to-start latency is 1 cycle: acceptance edge E0, then SEND occupies the cycle after E0.
  - Inter-byte gap is 2 cycles of controller overhead beyond the UART frame.
- Byte order: byte 0 = word[7:0] is sent first.
- Request handling:
  - The word is sampled only at acceptance. Later changes to word_in or dropping req do not affect the transfer in progress.
  - A req still high when the FSM returns to IDLE counts as a new request.
  - Simultaneous requests are resolved by the round-robin pointer. A continuously asserting requester cannot starve the others.
- Invariants:
  - At most one grant bit and one done bit are high in any cycle.
  - grant and done never occur in the same cycle.
- Illegal state encoding → IDLE on the next edge.

Decomposition:
- Shared package (tx_sched_pkg):
  - State encodings.
  - N_DATA / N_BYTES / NB_WORD defaults.
  - Byte-index width = clog2(N_BYTES).
- Sub-module rr_arbiter, combinational plus pointer register:
  - Inputs: req, pointer.
  - Outputs: one-hot winner and its index.
  - Pointer update enable driven by the FSM at acceptance.
- The FSM, word latch and byte mux stay in tx_word_scheduler.

Test Plan:
- Single word: req0=1 with word 0xDEADBEEF, UART model attached → exactly 4 tx_start pulses with uart_din EF, BE, AD, DE in order; grant[0] in the cycle after acceptance; done[0] once, after the fourth stop bit; busy drops the cycle after done.
- Simultaneous requests: req0=req1=1 from reset → requester 0 served first, then requester 1. With both held high for 4 words → grant order 0,1,0,1.
- Transmitter not ready: uart_tx_ready forced 0 in IDLE with req1=1 → no grant and no tx_start until ready returns to 1; then grant[1] appears 1 cycle later.
- Word stability: change word_in[0] to 0x12345678 right after grant[0] → bytes sent are still those of the originally latched 0xCAFEF00D (0D, F0, FE, CA).
- Reset mid-word: assert reset during byte 2 → all outputs go to reset values immediately, with no done. After release, a new req0 restarts from byte 0.
- Slow ready handshake: the UART model delays the drop of uart_tx_ready by 3 cycles → the FSM waits in WAIT_BUSY, issues no duplicate tx_start, and the full word is still transmitted correctly.
